// File: rtl/control_unit.sv
// control_unit: multi-cycle fetch/decode/execute sequencer for the accumulator datapath.
// Owns the PC and the 16-bit instruction register. It decodes the opcode, issues one-cycle
// EXEC strobes and resolves branches from the datapath Z/N flags.
// Ports: clock_in/reset_n_in (async, active-low); instruction_in from the program ROM,
// which is valid one cycle after pc_out; flag_Z_in/flag_N_in from the datapath status register.
// Outputs: pc_out, operand_out, ALU/mux selects, write strobes, datapath clears and halted_out.
module control_unit #(
  parameter int DATA_WIDTH   = 11,
  parameter int OPCODE_WIDTH = 5,
  parameter int PC_WIDTH     = 11
) (
  input  logic                               clock_in,
  input  logic                               reset_n_in,
  input  logic [OPCODE_WIDTH+DATA_WIDTH-1:0] instruction_in,
  input  logic                               flag_Z_in,
  input  logic                               flag_N_in,
  output logic [PC_WIDTH-1:0]                pc_out,
  output logic [DATA_WIDTH-1:0]              operand_out,
  output logic                               alu_op_out,
  output logic [1:0]                         sel_A_out,
  output logic                               sel_B_out,
  output logic                               acc_wr_out,
  output logic                               acc_reset_out,
  output logic                               status_wr_out,
  output logic                               status_reset_out,
  output logic                               data_memory_wr_out,
  output logic                               halted_out
);

  localparam int IW = OPCODE_WIDTH + DATA_WIDTH;

  typedef enum logic [2:0] {INIT, FETCH, DECODE, MEMRD, EXEC, HALT} state_t;

  localparam logic [OPCODE_WIDTH-1:0] OP_HLT  = 5'b00000;
  localparam logic [OPCODE_WIDTH-1:0] OP_STO  = 5'b00001;
  localparam logic [OPCODE_WIDTH-1:0] OP_LD   = 5'b00010;
  localparam logic [OPCODE_WIDTH-1:0] OP_LDI  = 5'b00011;
  localparam logic [OPCODE_WIDTH-1:0] OP_ADD  = 5'b00100;
  localparam logic [OPCODE_WIDTH-1:0] OP_ADDI = 5'b00101;
  localparam logic [OPCODE_WIDTH-1:0] OP_SUB  = 5'b00110;
  localparam logic [OPCODE_WIDTH-1:0] OP_SUBI = 5'b00111;
  localparam logic [OPCODE_WIDTH-1:0] OP_BEQ  = 5'b01000;
  localparam logic [OPCODE_WIDTH-1:0] OP_BNE  = 5'b01001;
  localparam logic [OPCODE_WIDTH-1:0] OP_BGT  = 5'b01010;
  localparam logic [OPCODE_WIDTH-1:0] OP_BGE  = 5'b01011;
  localparam logic [OPCODE_WIDTH-1:0] OP_BLT  = 5'b01100;
  localparam logic [OPCODE_WIDTH-1:0] OP_BLE  = 5'b01101;
  localparam logic [OPCODE_WIDTH-1:0] OP_JMP  = 5'b01110;

  state_t                  state, state_nxt;
  logic [PC_WIDTH-1:0]     pc;
  logic [IW-1:0]           ir;
  logic [OPCODE_WIDTH-1:0] ir_op;
  logic [OPCODE_WIDTH-1:0] in_op;
  logic                    take_branch;

  assign ir_op = ir[IW-1 -: OPCODE_WIDTH];
  assign in_op = instruction_in[IW-1 -: OPCODE_WIDTH];

  // Branch condition. The flags come from the previous instruction's status write.
  always_comb begin
    take_branch = 1'b0;
    case (ir_op)
      OP_BEQ:  take_branch = flag_Z_in;
      OP_BNE:  take_branch = !flag_Z_in;
      OP_BGT:  take_branch = !flag_Z_in && !flag_N_in;
      OP_BGE:  take_branch = !flag_N_in;
      OP_BLT:  take_branch = flag_N_in;
      OP_BLE:  take_branch = flag_N_in || flag_Z_in;
      OP_JMP:  take_branch = 1'b1;
      default: take_branch = 1'b0;
    endcase
  end

  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state <= INIT;
      pc    <= '0;
      ir    <= '0;
    end else begin
      state <= state_nxt;
      if (state == DECODE) begin
        ir <= instruction_in;
        pc <= pc + PC_WIDTH'(1);  // natural wrap from all-ones back to 0
      end else if (state == EXEC && take_branch) begin
        pc <= ir[PC_WIDTH-1:0];
      end
    end
  end

  // The next state is chosen in DECODE from the ROM word itself, because IR loads on the same edge.
  always_comb begin
    state_nxt = state;
    case (state)
      INIT:   state_nxt = FETCH;
      FETCH:  state_nxt = DECODE;
      DECODE: begin
        if (in_op == OP_HLT)
          state_nxt = HALT;
        else if (in_op == OP_LD || in_op == OP_ADD || in_op == OP_SUB)
          state_nxt = MEMRD;
        else
          state_nxt = EXEC;
      end
      MEMRD:  state_nxt = EXEC;
      EXEC:   state_nxt = FETCH;
      HALT:   state_nxt = HALT;
      default: state_nxt = INIT;
    endcase
  end

  // The strobes decode combinationally from the state, so an async reset clears them at once.
  always_comb begin
    alu_op_out         = 1'b0;
    sel_A_out          = 2'b00;
    sel_B_out          = 1'b0;
    acc_wr_out         = 1'b0;
    status_wr_out      = 1'b0;
    data_memory_wr_out = 1'b0;
    if (state == EXEC) begin
      case (ir_op)
        OP_STO:  data_memory_wr_out = 1'b1;
        OP_LD:   begin sel_A_out = 2'b01; acc_wr_out = 1'b1; status_wr_out = 1'b1; end
        OP_LDI:  begin sel_A_out = 2'b10; acc_wr_out = 1'b1; status_wr_out = 1'b1; end
        OP_ADD:  begin acc_wr_out = 1'b1; status_wr_out = 1'b1; end
        OP_ADDI: begin sel_B_out = 1'b1; acc_wr_out = 1'b1; status_wr_out = 1'b1; end
        OP_SUB:  begin alu_op_out = 1'b1; acc_wr_out = 1'b1; status_wr_out = 1'b1; end
        OP_SUBI: begin
          alu_op_out = 1'b1; sel_B_out = 1'b1; acc_wr_out = 1'b1; status_wr_out = 1'b1;
        end
        default: ;  // branches, NOP and illegal opcodes issue no strobes
      endcase
    end
  end

  assign pc_out           = pc;
  assign operand_out      = ir[DATA_WIDTH-1:0];
  assign acc_reset_out    = (state == INIT);
  assign status_reset_out = (state == INIT);
  assign halted_out       = (state == HALT);

endmodule
